// File: rtl/cache_main_ctrl_pkg.sv
// Shared definitions for the cache main controller: geometry, FSM states,
// memory request type codes and the store-lane strobe helper.
package cache_main_ctrl_pkg;

    localparam int unsigned CM_INDEXLEN = 8;
    localparam int unsigned CM_TAGLEN   = 20;
    localparam int unsigned CM_BEATS    = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS,
        S_REPLACE,
        S_REFILL,
        S_UCWR
    } state_t;

    localparam logic RD_WORD = 1'b0;
    localparam logic RD_LINE = 1'b1;
    localparam logic WR_WORD = 1'b0;
    localparam logic WR_LINE = 1'b1;

    // Places a 4-bit word strobe into its lane of the 16-byte line strobe.
    function automatic logic [15:0] lane_strb(input logic [1:0] lane, input logic [3:0] strb);
        return {12'b0, strb} << {lane, 2'b00};
    endfunction

endpackage

// File: rtl/cache_refill_buf.sv
// Refill assembly: beat counter, 128-bit line buffer, store merge into the
// refilled line, and detection of misplaced or stray ret_last.
module cache_refill_buf
    import cache_main_ctrl_pkg::*;
#(
    parameter int unsigned BEATS = CM_BEATS
)(
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         active,
    input  logic         ret_valid,
    input  logic         ret_last,
    input  logic [31:0]  ret_data,
    input  logic         uncache,
    input  logic         op,
    input  logic [1:0]   word_sel,
    input  logic [3:0]   wstrb,
    input  logic [31:0]  wdata,
    output logic [127:0] line,
    output logic [31:0]  word,
    output logic         err
);

    localparam int unsigned CW = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [127:0]  buf_q, buf_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            buf_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            buf_q <= buf_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        buf_d = buf_q;
        line  = buf_q;
        err   = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (active) begin
            if (ret_valid) begin
                line[32*int'(cnt_q) +: 32] = ret_data;
                buf_d = line;
                cnt_d = cnt_q + CW'(1);
                if (ret_last)
                    err = uncache ? (cnt_q != '0) : (cnt_q != CW'(BEATS - 1));
            end else if (ret_last) begin
                err = 1'b1;
            end
        end
        // Store data overlays the refilled line only on the write path, not in buf_q.
        for (int unsigned b = 0; b < 4; b++) begin
            if (op && wstrb[b])
                line[32*int'(word_sel) + 8*b +: 8] = wdata[8*b +: 8];
        end
        word = line[32*int'(word_sel) +: 32];
    end

endmodule

// File: rtl/cache_main_ctrl.sv
// Main sequencing FSM for a 2-way write-back, write-allocate cache:
// lookup, victim write-back, refill, and uncached load/store handshakes.
module cache_main_ctrl
    import cache_main_ctrl_pkg::*;
#(
    parameter int unsigned INDEXLEN = CM_INDEXLEN,
    parameter int unsigned TAGLEN   = CM_TAGLEN,
    parameter int unsigned BEATS    = CM_BEATS
)(
    input  logic                clk,
    input  logic                reset,
    input  logic                valid,
    input  logic                op,
    input  logic                uncache,
    input  logic [INDEXLEN-1:0] index,
    input  logic [TAGLEN-1:0]   tag,
    input  logic [3:0]          offset,
    input  logic [3:0]          wstrb,
    input  logic [31:0]         wdata,
    output logic                addr_ok,
    output logic                data_ok,
    output logic [31:0]         rdata,
    input  logic                hit,
    input  logic                hit_way,
    input  logic                victim_v,
    input  logic                victim_d,
    input  logic [TAGLEN-1:0]   victim_tag,
    input  logic [127:0]        victim_line,
    input  logic [31:0]         hit_word,
    output logic                bank_en,
    output logic [INDEXLEN-1:0] bank_idx,
    output logic                wr_way,
    output logic                tagv_wr,
    output logic                d_wr,
    output logic                d_set,
    output logic                data_wr,
    output logic [15:0]         data_wstrb,
    output logic [127:0]        data_wdata,
    output logic                en_for_miss,
    output logic                rd_req,
    output logic                rd_type,
    output logic [31:0]         rd_addr,
    input  logic                rd_rdy,
    input  logic                ret_valid,
    input  logic                ret_last,
    input  logic [31:0]         ret_data,
    output logic                wr_req,
    output logic                wr_type,
    output logic [31:0]         wr_addr,
    output logic [3:0]          wr_wstrb,
    output logic [127:0]        wr_data,
    input  logic                wr_rdy,
    output logic                err
);

    state_t              state_q, state_d;
    logic                op_q, op_d;
    logic                uncache_q, uncache_d;
    logic [INDEXLEN-1:0] index_q, index_d;
    logic [TAGLEN-1:0]   tag_q, tag_d;
    logic [3:0]          offset_q, offset_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic [31:0]         wdata_q, wdata_d;

    logic                rb_clear, rb_active, rb_err;
    logic [127:0]        rb_line;
    logic [31:0]         rb_word;

    cache_refill_buf #(.BEATS(BEATS)) u_refill_buf (
        .clk       (clk),
        .reset     (reset),
        .clear     (rb_clear),
        .active    (rb_active),
        .ret_valid (ret_valid),
        .ret_last  (ret_last),
        .ret_data  (ret_data),
        .uncache   (uncache_q),
        .op        (op_q),
        .word_sel  (offset_q[3:2]),
        .wstrb     (wstrb_q),
        .wdata     (wdata_q),
        .line      (rb_line),
        .word      (rb_word),
        .err       (rb_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= 1'b0;
            uncache_q <= 1'b0;
            index_q   <= '0;
            tag_q     <= '0;
            offset_q  <= '0;
            wstrb_q   <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            uncache_q <= uncache_d;
            index_q   <= index_d;
            tag_q     <= tag_d;
            offset_q  <= offset_d;
            wstrb_q   <= wstrb_d;
            wdata_q   <= wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        uncache_d   = uncache_q;
        index_d     = index_q;
        tag_d       = tag_q;
        offset_d    = offset_q;
        wstrb_d     = wstrb_q;
        wdata_d     = wdata_q;
        addr_ok     = 1'b0;
        data_ok     = 1'b0;
        rdata       = '0;
        bank_en     = 1'b0;
        bank_idx    = '0;
        wr_way      = 1'b0;
        tagv_wr     = 1'b0;
        d_wr        = 1'b0;
        d_set       = 1'b0;
        data_wr     = 1'b0;
        data_wstrb  = '0;
        data_wdata  = '0;
        en_for_miss = 1'b0;
        rd_req      = 1'b0;
        rd_type     = RD_WORD;
        rd_addr     = '0;
        wr_req      = 1'b0;
        wr_type     = WR_WORD;
        wr_addr     = '0;
        wr_wstrb    = '0;
        wr_data     = '0;
        err         = 1'b0;
        rb_clear    = 1'b0;
        rb_active   = 1'b0;

        // Outputs are held at zero while reset is asserted, whatever the state.
        if (!reset) begin
            unique case (state_q)
                S_IDLE: begin
                    addr_ok = valid;
                    if (valid) begin
                        op_d      = op;
                        uncache_d = uncache;
                        index_d   = index;
                        tag_d     = tag;
                        offset_d  = offset;
                        wstrb_d   = wstrb;
                        wdata_d   = wdata;
                        bank_en   = 1'b1;
                        bank_idx  = index;
                        state_d   = (uncache && op) ? S_UCWR : S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit && !uncache_q) begin
                        data_ok = 1'b1;
                        state_d = S_IDLE;
                        if (op_q) begin
                            bank_en    = 1'b1;
                            bank_idx   = index_q;
                            wr_way     = hit_way;
                            data_wr    = 1'b1;
                            d_wr       = 1'b1;
                            d_set      = 1'b1;
                            data_wstrb = lane_strb(offset_q[3:2], wstrb_q);
                            data_wdata = {4{wdata_q}};
                        end else begin
                            rdata = hit_word;
                        end
                    end else begin
                        state_d = S_MISS;
                    end
                end
                S_MISS: begin
                    if (!uncache_q && victim_v && victim_d) begin
                        wr_req  = 1'b1;
                        wr_type = WR_LINE;
                        wr_addr = {victim_tag, index_q, 4'b0000};
                        wr_data = victim_line;
                        if (wr_rdy)
                            state_d = S_REPLACE;
                    end else begin
                        state_d = S_REPLACE;
                    end
                end
                S_REPLACE: begin
                    rd_req  = 1'b1;
                    rd_type = uncache_q ? RD_WORD : RD_LINE;
                    rd_addr = uncache_q ? {tag_q, index_q, offset_q[3:2], 2'b00}
                                        : {tag_q, index_q, 4'b0000};
                    if (rd_rdy) begin
                        rb_clear = 1'b1;
                        state_d  = S_REFILL;
                    end
                end
                S_REFILL: begin
                    rb_active = 1'b1;
                    err       = rb_err;
                    if (ret_valid && ret_last) begin
                        data_ok = 1'b1;
                        state_d = S_IDLE;
                        if (uncache_q) begin
                            rdata = ret_data;
                        end else begin
                            bank_en     = 1'b1;
                            bank_idx    = index_q;
                            wr_way      = hit_way;
                            data_wr     = 1'b1;
                            data_wstrb  = '1;
                            data_wdata  = rb_line;
                            tagv_wr     = 1'b1;
                            d_wr        = 1'b1;
                            d_set       = op_q;
                            en_for_miss = 1'b1;
                            rdata       = rb_word;
                        end
                    end
                end
                S_UCWR: begin
                    wr_req   = 1'b1;
                    wr_type  = WR_WORD;
                    wr_addr  = {tag_q, index_q, offset_q[3:2], 2'b00};
                    wr_wstrb = wstrb_q;
                    wr_data  = {96'b0, wdata_q};
                    if (wr_rdy) begin
                        data_ok = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_main_ctrl.sv
// Directed bench for cache_main_ctrl: hits, clean/dirty misses, uncached
// accesses, refill protocol errors and reset during refill.
module tb_cache_main_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         valid, op, uncache;
    logic [7:0]   index;
    logic [19:0]  tag;
    logic [3:0]   offset, wstrb;
    logic [31:0]  wdata;
    logic         addr_ok, data_ok;
    logic [31:0]  rdata;
    logic         hit, hit_way, victim_v, victim_d;
    logic [19:0]  victim_tag;
    logic [127:0] victim_line;
    logic [31:0]  hit_word;
    logic         bank_en;
    logic [7:0]   bank_idx;
    logic         wr_way, tagv_wr, d_wr, d_set, data_wr;
    logic [15:0]  data_wstrb;
    logic [127:0] data_wdata;
    logic         en_for_miss, rd_req, rd_type;
    logic [31:0]  rd_addr;
    logic         rd_rdy, ret_valid, ret_last;
    logic [31:0]  ret_data;
    logic         wr_req, wr_type;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic         wr_rdy, err;

    cache_main_ctrl #(.INDEXLEN(8), .TAGLEN(20), .BEATS(4)) dut (
        .clk(clk), .reset(reset), .valid(valid), .op(op), .uncache(uncache),
        .index(index), .tag(tag), .offset(offset), .wstrb(wstrb), .wdata(wdata),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .hit(hit), .hit_way(hit_way), .victim_v(victim_v), .victim_d(victim_d),
        .victim_tag(victim_tag), .victim_line(victim_line), .hit_word(hit_word),
        .bank_en(bank_en), .bank_idx(bank_idx), .wr_way(wr_way), .tagv_wr(tagv_wr),
        .d_wr(d_wr), .d_set(d_set), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_wdata(data_wdata), .en_for_miss(en_for_miss),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
        .wr_data(wr_data), .wr_rdy(wr_rdy), .err(err)
    );

    always #5 clk = ~clk;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic next_cyc();
        @(negedge clk);
    endtask

    task automatic clr_in();
        valid = 0; op = 0; uncache = 0; index = '0; tag = '0; offset = '0;
        wstrb = '0; wdata = '0; hit = 0; hit_way = 0; victim_v = 0; victim_d = 0;
        victim_tag = '0; victim_line = '0; hit_word = '0; rd_rdy = 0;
        ret_valid = 0; ret_last = 0; ret_data = '0; wr_rdy = 0;
    endtask

    task automatic req(input logic o, input logic u, input logic [7:0] i, input logic [19:0] t,
                       input logic [3:0] off, input logic [3:0] s, input logic [31:0] d);
        valid = 1; op = o; uncache = u; index = i; tag = t; offset = off; wstrb = s; wdata = d;
        #1;
        check("addr_ok", addr_ok, 1);
        check("bank_idx", bank_idx, i);
        next_cyc();
        valid = 0; op = 0; uncache = 0; index = '0; tag = '0; offset = '0; wstrb = '0; wdata = '0;
    endtask

    task automatic lookup_miss(input logic h);
        hit = h;
        #1;
        check("lookup_no_data_ok", data_ok, 0);
        check("lookup_no_data_wr", data_wr, 0);
        next_cyc();
        hit = 0;
    endtask

    task automatic replace(input logic [31:0] addr, input logic typ, input int unsigned delay);
        for (int k = 0; k < int'(delay); k++) begin
            #1;
            check("rd_req_wait", rd_req, 1);
            next_cyc();
        end
        rd_rdy = 1;
        #1;
        check("rd_req", rd_req, 1);
        check("rd_addr", rd_addr, addr);
        check("rd_type", rd_type, typ);
        check("replace_no_wr_req", wr_req, 0);
        next_cyc();
        rd_rdy = 0;
    endtask

    // Returns four beats; leaves the final beat applied for the caller's checks.
    task automatic beats4(input logic [127:0] line);
        for (int i = 0; i < 4; i++) begin
            ret_valid = 1; ret_last = (i == 3); ret_data = line[32*i +: 32];
            #1;
            if (i < 3) begin
                check("refill_mid_en", en_for_miss, 0);
                check("refill_mid_data_ok", data_ok, 0);
                check("refill_mid_err", err, 0);
                next_cyc();
            end
        end
    endtask

    initial begin
        clr_in();
        reset = 1;
        valid = 1;
        @(negedge clk);
        #1;
        check("rst_addr_ok", addr_ok, 0);
        check("rst_bank_en", bank_en, 0);
        check("rst_rd_req", rd_req, 0);
        next_cyc();
        reset = 0; valid = 0;
        #1;
        check("idle_data_ok", data_ok, 0);
        next_cyc();

        // Load hit
        req(0, 0, 8'h12, 20'h11111, 4'h4, 4'h0, 32'h0);
        hit = 1; hit_word = 32'hDEADBEEF;
        #1;
        check("lh_data_ok", data_ok, 1);
        check("lh_rdata", rdata, 32'hDEADBEEF);
        check("lh_rd_req", rd_req, 0);
        check("lh_wr_req", wr_req, 0);
        check("lh_data_wr", data_wr, 0);
        next_cyc();
        clr_in();
        #1;
        check("lh_after", data_ok, 0);
        next_cyc();

        // Store hit
        req(1, 0, 8'h34, 20'h22222, 4'h8, 4'b0011, 32'h11223344);
        hit = 1; hit_way = 1;
        #1;
        check("sh_data_ok", data_ok, 1);
        check("sh_data_wstrb", data_wstrb, 16'h0300);
        check("sh_data_wr", data_wr, 1);
        check("sh_d_wr", d_wr, 1);
        check("sh_d_set", d_set, 1);
        check("sh_wr_way", wr_way, 1);
        check("sh_wdata", data_wdata, {4{32'h11223344}});
        check("sh_tagv_wr", tagv_wr, 0);
        next_cyc();
        clr_in();

        // Clean load miss, rd_rdy after two cycles
        req(0, 0, 8'h40, 20'h12345, 4'hC, 4'h0, 32'h0);
        lookup_miss(0);
        victim_v = 1; victim_d = 0;
        #1;
        check("clean_no_wb", wr_req, 0);
        next_cyc();
        replace(32'h12345400, 1'b1, 2);
        hit_way = 1;
        beats4({32'h4, 32'h3, 32'h2, 32'h1});
        check("clm_data_ok", data_ok, 1);
        check("clm_rdata", rdata, 32'h4);
        check("clm_wstrb", data_wstrb, 16'hFFFF);
        check("clm_wdata", data_wdata, {32'h4, 32'h3, 32'h2, 32'h1});
        check("clm_tagv_wr", tagv_wr, 1);
        check("clm_d_set", d_set, 0);
        check("clm_en", en_for_miss, 1);
        check("clm_wr_way", wr_way, 1);
        check("clm_bank_idx", bank_idx, 8'h40);
        check("clm_err", err, 0);
        next_cyc();
        clr_in();
        #1;
        check("clm_en_once", en_for_miss, 0);
        check("clm_after_data_ok", data_ok, 0);
        next_cyc();

        // Dirty store miss with victim write-back
        req(1, 0, 8'h05, 20'h55555, 4'h4, 4'b1100, 32'hAABBCCDD);
        lookup_miss(0);
        victim_v = 1; victim_d = 1; victim_tag = 20'hABCDE;
        victim_line = 128'h0123456789ABCDEF_FEDCBA9876543210;
        #1;
        check("dsm_wr_req", wr_req, 1);
        check("dsm_wr_addr", wr_addr, 32'hABCDE050);
        check("dsm_wr_type", wr_type, 1);
        check("dsm_wr_data", wr_data, 128'h0123456789ABCDEF_FEDCBA9876543210);
        check("dsm_no_rd_yet", rd_req, 0);
        next_cyc();
        wr_rdy = 1;
        #1;
        check("dsm_wr_hold", wr_req, 1);
        next_cyc();
        wr_rdy = 0; victim_v = 0; victim_d = 0;
        replace(32'h55555050, 1'b1, 0);
        beats4({32'h40, 32'h30, 32'h20, 32'h10});
        check("dsm_wdata", data_wdata, {32'h40, 32'h30, 32'hAABB0020, 32'h10});
        check("dsm_d_set", d_set, 1);
        check("dsm_rdata", rdata, 32'hAABB0020);
        check("dsm_data_ok", data_ok, 1);
        next_cyc();
        clr_in();

        // Uncached load: dirty victim must not be written back
        req(0, 1, 8'h77, 20'h0F0F0, 4'h6, 4'h0, 32'h0);
        lookup_miss(1);
        victim_v = 1; victim_d = 1;
        #1;
        check("ucl_no_wb", wr_req, 0);
        next_cyc();
        victim_v = 0; victim_d = 0;
        replace(32'h0F0F0774, 1'b0, 0);
        ret_valid = 1; ret_last = 1; ret_data = 32'hCAFEF00D;
        #1;
        check("ucl_data_ok", data_ok, 1);
        check("ucl_rdata", rdata, 32'hCAFEF00D);
        check("ucl_data_wr", data_wr, 0);
        check("ucl_tagv_wr", tagv_wr, 0);
        check("ucl_en", en_for_miss, 0);
        check("ucl_err", err, 0);
        next_cyc();
        clr_in();

        // Uncached store
        req(1, 1, 8'h22, 20'h00ABC, 4'hE, 4'b0101, 32'h12345678);
        #1;
        check("ucs_wr_req", wr_req, 1);
        check("ucs_wr_type", wr_type, 0);
        check("ucs_wr_addr", wr_addr, 32'h00ABC22C);
        check("ucs_wr_wstrb", wr_wstrb, 4'b0101);
        check("ucs_wr_data", wr_data, 128'h12345678);
        check("ucs_wait_data_ok", data_ok, 0);
        next_cyc();
        wr_rdy = 1;
        #1;
        check("ucs_data_ok", data_ok, 1);
        check("ucs_data_wr", data_wr, 0);
        next_cyc();
        clr_in();

        // Stray ret_last, then early ret_last at beat 1
        req(0, 0, 8'h01, 20'h00001, 4'h0, 4'h0, 32'h0);
        lookup_miss(0);
        next_cyc();
        replace(32'h00001010, 1'b1, 0);
        ret_last = 1;
        #1;
        check("stray_last_err", err, 1);
        check("stray_last_data_ok", data_ok, 0);
        next_cyc();
        ret_valid = 1; ret_last = 0; ret_data = 32'hA0;
        #1;
        check("early_b0_err", err, 0);
        next_cyc();
        ret_last = 1; ret_data = 32'hA1;
        #1;
        check("early_err", err, 1);
        check("early_data_ok", data_ok, 1);
        check("early_data_wr", data_wr, 1);
        check("early_rdata", rdata, 32'hA0);
        next_cyc();
        clr_in();
        #1;
        check("early_err_pulse", err, 0);
        next_cyc();

        // Reset mid-refill
        req(0, 0, 8'h09, 20'h00009, 4'h0, 4'h0, 32'h0);
        lookup_miss(0);
        next_cyc();
        replace(32'h00009090, 1'b1, 0);
        ret_valid = 1; ret_data = 32'h55;
        #1;
        next_cyc();
        reset = 1; ret_last = 1;
        #1;
        check("rstmid_data_ok", data_ok, 0);
        check("rstmid_data_wr", data_wr, 0);
        check("rstmid_err", err, 0);
        next_cyc();
        reset = 0; clr_in();
        #1;
        check("rstmid_rd_req", rd_req, 0);
        check("rstmid_bank_en", bank_en, 0);
        check("rstmid_data_ok2", data_ok, 0);
        check("rstmid_en", en_for_miss, 0);

        // Full miss after reset: beat counter must restart cleanly
        req(0, 0, 8'h0A, 20'h0000A, 4'h4, 4'h0, 32'h0);
        lookup_miss(0);
        next_cyc();
        replace(32'h0000A0A0, 1'b1, 0);
        beats4({32'hD3, 32'hD2, 32'hD1, 32'hD0});
        check("post_rst_err", err, 0);
        check("post_rst_rdata", rdata, 32'hD1);
        next_cyc();
        clr_in();
        next_cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
